// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter and pin sequencer for an asynchronous SRAM, lower byte lane
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [17:0] addr0,
  input  logic [17:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic        busy,
  output logic [17:0] sram_addr,
  inout  wire  [7:0]  sram_data,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int CW = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;
  logic          port_q;
  logic          we_q;
  logic [7:0]    wdata_q;
  logic          data_oe;

  logic          win;
  logic          grant;
  logic          port_nx;
  logic          we_nx;

  logic          ce_n_d;
  logic          oe_n_d;
  logic          we_n_d;
  logic          data_oe_d;
  logic          busy_d;
  logic          done0_d;
  logic          done1_d;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // Port that wins the next tie; flips away from whichever port just completed.
  logic          rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (state == DONE) begin
      rr_ptr <= ~port_q;
    end
  end

  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = rr_ptr;
    end else if (req1) begin
      win = 1'b1;
    end
  end
`else
  always_comb begin
    win = 1'b0;
    if (!req0 && req1) begin
      win = 1'b1;
    end
  end
`endif

  assign grant   = (state == IDLE) && (req0 || req1);
  assign port_nx = grant ? win : port_q;
  assign we_nx   = grant ? (win ? we1 : we0) : we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req0 || req1) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (wait_cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Values the pins take in the upcoming state; they are registered below so every pin is glitch-free.
  always_comb begin
    ce_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    data_oe_d = 1'b0;
    busy_d    = (next_state != IDLE);
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    case (next_state)
      SETUP: begin
        ce_n_d    = 1'b0;
        oe_n_d    = we_nx;
        data_oe_d = we_nx;
      end
      ACCESS: begin
        ce_n_d    = 1'b0;
        oe_n_d    = we_nx;
        we_n_d    = ~we_nx;
        data_oe_d = we_nx;
      end
      DONE: begin
        ce_n_d    = 1'b0;
        data_oe_d = we_nx;
        done0_d   = ~port_nx;
        done1_d   = port_nx;
      end
      default: begin
        ce_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= 8'h00;
      sram_addr <= 18'h00000;
      rdata0    <= 8'h00;
      rdata1    <= 8'h00;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      data_oe   <= 1'b0;
      busy      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
    end else begin
      sram_ce_n <= ce_n_d;
      sram_oe_n <= oe_n_d;
      sram_we_n <= we_n_d;
      data_oe   <= data_oe_d;
      busy      <= busy_d;
      done0     <= done0_d;
      done1     <= done1_d;
      if (grant) begin
        port_q    <= win;
        we_q      <= win ? we1 : we0;
        wdata_q   <= win ? wdata1 : wdata0;
        sram_addr <= win ? addr1 : addr0;
      end
      if (state == SETUP) begin
        wait_cnt <= CW'(WAIT_CYCLES - 1);
      end else if (state == ACCESS && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - CW'(1);
      end
      // Read data is captured on the last ACCESS edge, while oe_n is still low.
      if (state == ACCESS && wait_cnt == '0 && !we_q) begin
        if (port_q) begin
          rdata1 <= sram_data;
        end else begin
          rdata0 <= sram_data;
        end
      end
    end
  end

  assign sram_data = data_oe ? wdata_q : 8'hzz;
  assign sram_ub_n = 1'b1;
  assign sram_lb_n = 1'b0;

endmodule
